// File: rtl/irq_share_pkg.sv
// irq_share_pkg: shared FSM state encoding and default sizing for the irq sharing controller
//   state_t           controller FSM states
//   DEF_NREQ          default number of requesters
//   DEF_TIMEOUT       default watchdog length in WAIT cycles
//   DEF_MAX_BURST     default number of acknowledged transfers per grant
package irq_share_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CONT, RELEASE} state_t;
   localparam int DEF_NREQ      = 4;
   localparam int DEF_TIMEOUT   = 16;
   localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of req searching upward from ptr with wrap
//   req     in   N       request vector
//   ptr     in   IW      search start index (0..N-1)
//   onehot  out  N       one-hot winner, zero when no request
//   idx     out  IW      binary winner index, zero when no request
//   any     out  1       at least one request present
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   // one extra bit so ptr+i can exceed N-1 before the wrap subtraction
   logic [IW:0] k;
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = |req;
      k      = '0;
      // scan farthest offset first so the nearest set bit is the last to write
      for (int i = N - 1; i >= 0; i--) begin
         k = {1'b0, ptr} + (IW+1)'(i);
         if (k >= (IW+1)'(N)) k = k - (IW+1)'(N);
         if (req[k[IW-1:0]]) begin
            idx    = k[IW-1:0];
            onehot = N'(1) << k[IW-1:0];
         end
      end
   end
endmodule

// File: rtl/irq_share_ctrl.sv
// irq_share_ctrl: round-robin sharing of one interrupt-handler FSM between NREQ requesters
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req, burst          per-requester request level and continuation wish
//   hnd_ackout          handler ACKOUT
//   hnd_enable_count    handler ENABLE_COUNT, freezes the watchdog while high
//   eql, cont_eql       to handler EQL / CONT_EQL
//   grant, grant_id     one-hot owner (zero when idle) and its index (held when idle)
//   done, timeout_err   per-transfer done pulse to owner, watchdog abort pulse
//   busy                controller not in IDLE
module irq_share_ctrl
   import irq_share_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         burst,
   input  logic                    hnd_ackout,
   input  logic                    hnd_enable_count,
   output logic                    eql,
   output logic                    cont_eql,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic [NREQ-1:0]         done,
   output logic                    timeout_err,
   output logic                    busy
);
   localparam int IW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_t          state, state_n;
   logic [IW-1:0]   rr_ptr, rr_ptr_n, grant_id_n, pick_idx;
   logic [BW-1:0]   burst_cnt, burst_cnt_n;
   logic [WW-1:0]   wd_cnt, wd_cnt_n;
   logic [NREQ-1:0] grant_n, done_n, pick_onehot;
   logic            eql_n, cont_eql_n, timeout_err_n, busy_n, pick_any;

   rr_pick #(.N(NREQ), .IW(IW)) u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_n       = state;
      rr_ptr_n      = rr_ptr;
      burst_cnt_n   = burst_cnt;
      wd_cnt_n      = wd_cnt;
      grant_id_n    = grant_id;
      done_n        = '0;
      timeout_err_n = 1'b0;
      case (state)
         IDLE:
            if (pick_any) begin
               state_n     = ISSUE;
               grant_id_n  = pick_idx;
               burst_cnt_n = '0;
            end
         ISSUE: begin
            wd_cnt_n = '0;
            state_n  = WAIT;
         end
         WAIT:
            // ack beats abandon beats watchdog
            if (hnd_ackout) begin
               done_n      = grant;
               burst_cnt_n = burst_cnt + BW'(1);
               state_n     = (burst[grant_id] && req[grant_id] && (int'(burst_cnt) + 1 < MAX_BURST)) ? CONT : RELEASE;
            end else if (!req[grant_id]) begin
               state_n = RELEASE;
            end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
               timeout_err_n = 1'b1;
               state_n       = RELEASE;
            end else if (!hnd_enable_count) begin
               wd_cnt_n = wd_cnt + WW'(1);
            end
         CONT: begin
            wd_cnt_n = '0;
            state_n  = WAIT;
         end
         RELEASE: begin
            rr_ptr_n = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IW'(1);
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // outputs are registered, so they are derived from the next state
      eql_n      = (state_n == ISSUE) || (state_n == WAIT) || (state_n == CONT);
      cont_eql_n = state_n == CONT;
      busy_n     = state_n != IDLE;
      grant_n    = !eql_n ? '0 : (state == IDLE) ? pick_onehot : grant;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         burst_cnt   <= '0;
         wd_cnt      <= '0;
         eql         <= 1'b0;
         cont_eql    <= 1'b0;
         grant       <= '0;
         grant_id    <= '0;
         done        <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         rr_ptr      <= rr_ptr_n;
         burst_cnt   <= burst_cnt_n;
         wd_cnt      <= wd_cnt_n;
         eql         <= eql_n;
         cont_eql    <= cont_eql_n;
         grant       <= grant_n;
         grant_id    <= grant_id_n;
         done        <= done_n;
         timeout_err <= timeout_err_n;
         busy        <= busy_n;
      end
   end
endmodule

// File: doc/irq_share_ctrl.md
Name: irq_share_ctrl

Overview:
- Round-robin controller that shares one interrupt-handler FSM (EQL/CONT_EQL in, ACKOUT/ENABLE_COUNT out) between NREQ requesters.
- Sequences the handler: selects a requester, drives eql/cont_eql, waits for the handler's acknowledge, then returns a done pulse to the winner.
- Bounded bursts and a watchdog timeout prevent a stalled handler or requester from locking the resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, cycles in WAIT without hnd_ackout before abort (≥2).
- MAX_BURST, 4, maximum acknowledged transfers per grant (≥1).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; held until done or abandoned.
- burst  in  NREQ  requester wants continuation after the current ack.
- hnd_ackout  in  1  handler ACKOUT.
- hnd_enable_count  in  1  handler ENABLE_COUNT; while high, the timeout counter is frozen.
- eql  out  1  to handler EQL.
- cont_eql  out  1  to handler CONT_EQL.
- grant  out  NREQ  one-hot owner; zero when idle.
- grant_id  out  $clog2(NREQ)  binary index of owner; holds its last value when idle.
- done  out  NREQ  one-cycle pulse per acknowledged transfer to the owner.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset, sampled at a clock edge, takes effect on the next cycle and overrides every other event, including mid-grant:
  - state=IDLE, rr_ptr=0, burst_cnt=0, wd_cnt=0.
  - eql, cont_eql, grant, grant_id, done, timeout_err and busy are all 0.
  - The handler sees eql drop in the same cycle.
- States: IDLE, ISSUE, WAIT, CONT, RELEASE.
- IDLE:
  - If req≠0, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Next cycle: ISSUE, grant/grant_id set, eql=1, burst_cnt=0.
  - Latency is 1 cycle from req sampled to grant visible.
- ISSUE: lasts 1 cycle with eql=1. wd_cnt is cleared, then the FSM goes to WAIT.
- WAIT: eql=1. Exits are evaluated in this priority order:
  1. hnd_ackout=1: done[id] pulses next cycle and burst_cnt increments. If burst[id]&req[id] and burst_cnt+1<MAX_BURST, go to CONT; otherwise go to RELEASE.
  2. req[id]=0 (abandon): go to RELEASE with no done.
  3. wd_cnt==TIMEOUT-1: timeout_err pulses next cycle, then RELEASE.
  4. Otherwise wd_cnt increments, unless hnd_enable_count=1 (hold).
  - An ack and a timeout in the same cycle count as an ack. An ack and a req drop in the same cycle count as an ack.
- CONT:
  - 1 cycle with eql=1 and cont_eql=1. wd_cnt is cleared.
  - The FSM then returns to WAIT.
  - cont_eql is never high outside CONT.
- RELEASE:
  - 1 cycle with eql=0, cont_eql=0, grant=0.
  - rr_ptr = (id+1) mod NREQ, then the FSM goes to IDLE.
  - This gives a minimum 1-cycle handler idle gap between owners and guarantees no back-to-back grants to the same requester while another requests.
- Invariants: grant is one-hot or zero; done is a subset of grant's previous value; at most one done bit is set per cycle.
- Width rules:
  - wd_cnt is $clog2(TIMEOUT) bits and burst_cnt is $clog2(MAX_BURST+1) bits; neither wraps.
  - rr_ptr wraps NREQ-1 → 0, so non-power-of-2 NREQ is legal.
- A request that appears while another owner holds the grant waits; there is no preemption.

Decomposition:
- Shared package irq_share_pkg:
  - state enum (IDLE, ISSUE, WAIT, CONT, RELEASE).
  - Default constants for NREQ, TIMEOUT and MAX_BURST.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner, index, any.
  - Reusable by the other arbiters in the suite.

Test Plan (NREQ=4, TIMEOUT=16, MAX_BURST=4):
- Single request: reset, then req=4'b0100 at cycle 2. Expect grant=4'b0100, grant_id=2, eql=1 at cycle 3. Ack at cycle 6 → done=4'b0100 at cycle 7, RELEASE, grant=0 at cycle 8, rr_ptr=3.
- Fairness: req=4'b1111 held, ack one cycle after each ISSUE, burst=0. Grant order is 0,1,2,3,0 with an eql=0 gap cycle between owners.
- Burst cap: req[1]=burst[1]=1 with an immediate ack every WAIT. Expect exactly 4 done pulses, cont_eql high 3 times, then RELEASE.
- Timeout: req[3]=1, no ack ever. timeout_err pulses exactly 16 cycles after entering WAIT, with no done; with hnd_enable_count high for 5 of those cycles, the timeout fires 21 cycles after entering WAIT.
- Abandon and simultaneous events:
  - req[0] dropped in WAIT → RELEASE with no done and no timeout_err.
  - Ack coincident with the watchdog expiry → done only.
  - Ack coincident with a req drop → done.
- Reset mid-burst: assert reset during CONT. Next cycle all outputs are 0 and state is IDLE; a later req=4'b0010 wins from rr_ptr=0.
